mem_responder: RTL and testbench

- Memory-side responder for the multi_cycle core's data/instruction memory interface.
- The core is the initiator. It presents dataaddr, writedata and memwrite with a req strobe.
- This block services each request after a programmable number of wait states and returns readdata with a one-cycle ready pulse.
- A side load port lets benches preload hand-assembled machine code before the core runs.

---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Core-side memory bus between the multi_cycle core (master) and mem_responder (slave),
// plus the preload side port used by benches.
interface mem_responder_if;
  // Handshake: the master raises req with memwrite/dataaddr/writedata stable. The slave
  // takes them at the first IDLE edge with load_en=0 and answers with a one-cycle ready
  // pulse; readdata/err are valid while ready=1. The master drops req once it sees ready.
  logic        req;
  logic        memwrite;
  logic [15:0] dataaddr;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        ready;
  logic        err;
  logic        busy;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic [1:0]  dbg_state;

  modport master (
    output req, memwrite, dataaddr, writedata, load_en, load_addr, load_data,
    input  readdata, ready, err, busy, dbg_state
  );

  modport slave (
    input  req, memwrite, dataaddr, writedata, load_en, load_addr, load_data,
    output readdata, ready, err, busy, dbg_state
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: services one core access after WAIT_CYCLES wait
// states and signals completion with a one-cycle ready pulse; preloadable via load port.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] readdata_q;
  logic        err_q;
  logic        ready_q;
  logic        busy_q;

  logic [15:0] mem [DEPTH];

  logic          accept;
  logic          access_now;
  logic          acc_we;
  logic [15:0]   acc_addr;
  logic [15:0]   acc_wdata;
  logic          acc_in_range;
  logic [AW-1:0] acc_idx;
  logic [15:0]   readdata_d;
  logic          err_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic          unused_bits;

  assign accept = (state_q == S_IDLE) && !bus.load_en && bus.req;

  // With zero wait states the access completes on the accept edge, so it must use the
  // live bus inputs rather than the latched copies.
  always_comb begin
    access_now = 1'b0;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    if (WAIT_CYCLES == 0) begin
      if (accept) begin
        access_now = 1'b1;
        acc_we     = bus.memwrite;
        acc_addr   = bus.dataaddr;
        acc_wdata  = bus.writedata;
      end
    end else if ((state_q == S_WAIT) && (cnt_q == 4'd1)) begin
      access_now = 1'b1;
    end
  end

  assign acc_in_range = ({1'b0, acc_addr} < 17'(DEPTH));
  assign acc_idx      = acc_addr[AW-1:0];

  always_comb begin
    readdata_d = 16'h0000;
    err_d      = 1'b1;
    if (acc_in_range) begin
      err_d      = 1'b0;
      readdata_d = acc_we ? acc_wdata : mem[acc_idx];
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = acc_idx;
    mem_wdata = acc_wdata;
    if ((state_q == S_IDLE) && bus.load_en) begin
      mem_we    = 1'b1;
      mem_waddr = bus.load_addr[AW-1:0];
      mem_wdata = bus.load_data;
    end else if (access_now && acc_we && acc_in_range) begin
      mem_we = 1'b1;
    end
  end

  // Storage is deliberately outside the reset domain: reset never clears contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      readdata_q <= 16'h0000;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q    <= bus.memwrite;
            addr_q  <= bus.dataaddr;
            wdata_q <= bus.writedata;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q    <= S_DONE;
              ready_q    <= 1'b1;
              readdata_q <= readdata_d;
              err_q      <= err_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q    <= S_DONE;
            ready_q    <= 1'b1;
            readdata_q <= readdata_d;
            err_q      <= err_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readdata  = readdata_q;
  assign bus.err       = err_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state_q;

  assign unused_bits = ^{bus.load_addr, 1'b0};

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a 256-word/2-wait instance and a 16-word/0-wait instance,
// checked against an array model of memory and the latency rules.
module tb_mem_responder;

  localparam int W0 = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if if0();
  mem_responder_if if1();

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(W0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mem_responder #(.DEPTH(16),  .WAIT_CYCLES(0))  dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] ref0 [256];
  logic [15:0] ref1 [16];

  task automatic load_word(input bit sel, input logic [15:0] a, input logic [15:0] d);
    repeat (2) @(negedge clk);
    if (!sel) begin
      if0.load_en = 1'b1; if0.load_addr = a; if0.load_data = d;
      ref0[a % 256] = d;
    end else begin
      if1.load_en = 1'b1; if1.load_addr = a; if1.load_data = d;
      ref1[a % 16] = d;
    end
    @(negedge clk);
    if0.load_en = 1'b0;
    if1.load_en = 1'b0;
  endtask

  // One access on the 256-word instance: predicts the result from the model, drives the
  // request, and reports the accept edge and ready edge it observed.
  task automatic run0(input bit we, input logic [15:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output logic [15:0] erd,
                      output bit e, output bit ee, output int lat,
                      output int acc_c, output int rdy_c);
    bit idle_pre;
    bit done;
    if (a >= 16'd256) begin
      erd = 16'h0000; ee = 1'b1;
    end else if (we) begin
      ref0[a[7:0]] = wd; erd = wd; ee = 1'b0;
    end else begin
      erd = ref0[a[7:0]]; ee = 1'b0;
    end
    idle_pre = !if0.busy;
    if0.req = 1'b1; if0.memwrite = we; if0.dataaddr = a; if0.writedata = wd;
    acc_c = -1; rdy_c = -1; done = 1'b0; rd = 16'h0000; e = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      if (acc_c < 0 && idle_pre) acc_c = cyc;
      if (if0.ready) begin
        rdy_c = cyc; rd = if0.readdata; e = if0.err; done = 1'b1;
      end
      idle_pre = !if0.busy;
    end
    if0.req = 1'b0;
    lat = rdy_c - acc_c;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL run0_timeout addr=%h no ready within 40 cycles", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({if0.ready, if0.busy, if0.err, if0.readdata} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_dut0 got rdy=%b busy=%b err=%b rd=%h want all 0",
               if0.ready, if0.busy, if0.err, if0.readdata);
    end
    n_tests++;
    if ({if1.ready, if1.busy, if1.err, if1.readdata} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_dut1 got rdy=%b busy=%b err=%b rd=%h want all 0",
               if1.ready, if1.busy, if1.err, if1.readdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_preload_read();
    logic [15:0] words [4];
    logic [15:0] rd, erd;
    bit e, ee;
    int lat, ac, rc;
    words[0] = 16'h02a2; words[1] = 16'h084a; words[2] = 16'h0dfa; words[3] = 16'h0ffa;
    for (int i = 0; i < 4; i++) load_word(1'b0, 16'(i), words[i]);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run0(1'b0, 16'(i), 16'h0, rd, erd, e, ee, lat, ac, rc);
      n_tests++;
      if ({e, rd} !== {1'b0, words[i]}) begin
        n_fail++;
        $display("FAIL preload_read[%0d] got err=%b rd=%h want err=0 rd=%h", i, e, rd, words[i]);
      end
      n_tests++;
      if (lat !== W0) begin
        n_fail++;
        $display("FAIL preload_latency[%0d] got %0d want %0d", i, lat, W0);
      end
    end
  endtask

  task automatic test_write_read();
    logic [15:0] rd, erd;
    bit e, ee;
    int lat, ac1, rc1, ac2, rc2;
    run0(1'b1, 16'd5, 16'h1234, rd, erd, e, ee, lat, ac1, rc1);
    n_tests++;
    if ({e, rd} !== {1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL write_echo got err=%b rd=%h want err=0 rd=1234", e, rd);
    end
    run0(1'b0, 16'd5, 16'h0, rd, erd, e, ee, lat, ac2, rc2);
    n_tests++;
    if ({e, rd} !== {1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL read_after_write got err=%b rd=%h want err=0 rd=1234", e, rd);
    end
    n_tests++;
    if ((rc2 - ac1 + 2) !== 2 * (W0 + 2)) begin
      n_fail++;
      $display("FAIL pair_cycles got %0d want %0d", rc2 - ac1 + 2, 2 * (W0 + 2));
    end
    n_tests++;
    if ((ac2 - ac1) !== (W0 + 2)) begin
      n_fail++;
      $display("FAIL b2b_throughput got %0d want %0d", ac2 - ac1, W0 + 2);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd, erd;
    bit e, ee;
    int lat, ac, rc;
    run0(1'b0, 16'h0100, 16'h0, rd, erd, e, ee, lat, ac, rc);
    n_tests++;
    if ({e, rd} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL oor_read got err=%b rd=%h want err=1 rd=0000", e, rd);
    end
    run0(1'b1, 16'h0100, 16'hBEEF, rd, erd, e, ee, lat, ac, rc);
    n_tests++;
    if ({e, rd} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL oor_write got err=%b rd=%h want err=1 rd=0000", e, rd);
    end
    run0(1'b0, 16'h0000, 16'h0, rd, erd, e, ee, lat, ac, rc);
    n_tests++;
    if ({e, rd} !== {ee, erd}) begin
      n_fail++;
      $display("FAIL oor_no_alias got err=%b rd=%h want err=%b rd=%h", e, rd, ee, erd);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] rd, erd;
    bit e, ee;
    int lat, ac, rc;
    load_word(1'b0, 16'd7, 16'h5555);
    @(negedge clk);
    if0.req = 1'b1; if0.memwrite = 1'b1; if0.dataaddr = 16'd7; if0.writedata = 16'hAAAA;
    @(posedge clk); #1;
    n_tests++;
    if (if0.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_accept got busy=%b want 1", if0.busy);
    end
    #2;
    reset = 1'b0;
    if0.req = 1'b0;
    #1;
    n_tests++;
    if ({if0.ready, if0.busy, if0.err, if0.readdata} !== 19'd0) begin
      n_fail++;
      $display("FAIL rst_wait_async got rdy=%b busy=%b err=%b rd=%h want all 0",
               if0.ready, if0.busy, if0.err, if0.readdata);
    end
    @(negedge clk);
    reset = 1'b1;
    run0(1'b0, 16'd7, 16'h0, rd, erd, e, ee, lat, ac, rc);
    n_tests++;
    if ({e, rd} !== {1'b0, 16'h5555}) begin
      n_fail++;
      $display("FAIL rst_wait_no_commit got err=%b rd=%h want err=0 rd=5555", e, rd);
    end
  endtask

  task automatic test_load_and_req();
    int ac, rc;
    logic [15:0] rd;
    repeat (2) @(negedge clk);
    if0.load_en = 1'b1; if0.load_addr = 16'd9; if0.load_data = 16'h0042;
    ref0[9] = 16'h0042;
    if0.req = 1'b1; if0.memwrite = 1'b0; if0.dataaddr = 16'd9;
    @(posedge clk); #1;
    n_tests++;
    if (if0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_blocks_req got busy=%b want 0", if0.busy);
    end
    @(negedge clk);
    if0.load_en = 1'b0;
    @(posedge clk); #1;
    ac = cyc;
    rc = -1; rd = 16'h0000;
    n_tests++;
    if (if0.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_then_accept got busy=%b want 1", if0.busy);
    end
    for (int k = 0; k < 10 && rc < 0; k++) begin
      @(posedge clk); #1;
      if (if0.ready) begin rc = cyc; rd = if0.readdata; end
    end
    if0.req = 1'b0;
    n_tests++;
    if (rd !== 16'h0042 || (rc - ac) !== W0) begin
      n_fail++;
      $display("FAIL load_then_read got rd=%h lat=%0d want rd=0042 lat=%0d", rd, rc - ac, W0);
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, erd, a, wd;
    bit e, ee, we;
    int lat, ac, rc;
    for (int i = 0; i < 256; i++)
      load_word(1'b0, 16'(i + 256 * $urandom_range(0, 1)), 16'($urandom));
    repeat (2) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom_range(0, 299));
      wd = 16'($urandom);
      we = 1'($urandom_range(0, 1));
      run0(we, a, wd, rd, erd, e, ee, lat, ac, rc);
      n_tests++;
      if ({e, rd} !== {ee, erd} || lat !== W0) begin
        n_fail++;
        $display("FAIL random[%0d] we=%b addr=%h got err=%b rd=%h lat=%0d want err=%b rd=%h lat=%0d",
                 i, we, a, e, rd, lat, ee, erd, W0);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [15:0] addrs [5];
    logic [15:0] erd;
    bit ee;
    for (int i = 0; i < 3; i++) load_word(1'b1, 16'(20 + i), 16'($urandom));
    addrs[0] = 16'd4; addrs[1] = 16'd5; addrs[2] = 16'd6; addrs[3] = 16'd16; addrs[4] = 16'd0;
    repeat (2) @(negedge clk);
    if1.req = 1'b1; if1.memwrite = 1'b0; if1.dataaddr = addrs[0];
    for (int i = 0; i < 4; i++) begin
      ee  = (addrs[i] >= 16'd16);
      erd = ee ? 16'h0000 : ref1[addrs[i][3:0]];
      @(posedge clk); #1;
      n_tests++;
      if ({if1.ready, if1.busy, if1.err, if1.readdata} !== {1'b1, 1'b1, ee, erd}) begin
        n_fail++;
        $display("FAIL zw_done[%0d] got rdy=%b busy=%b err=%b rd=%h want rdy=1 busy=1 err=%b rd=%h",
                 i, if1.ready, if1.busy, if1.err, if1.readdata, ee, erd);
      end
      if1.dataaddr = addrs[i+1];
      @(posedge clk); #1;
      n_tests++;
      if ({if1.ready, if1.busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL zw_idle[%0d] got rdy=%b busy=%b want 0 0", i, if1.ready, if1.busy);
      end
    end
    if1.req = 1'b0;
  endtask

  initial begin
    if0.req = 1'b0; if0.memwrite = 1'b0; if0.dataaddr = '0; if0.writedata = '0;
    if0.load_en = 1'b0; if0.load_addr = '0; if0.load_data = '0;
    if1.req = 1'b0; if1.memwrite = 1'b0; if1.dataaddr = '0; if1.writedata = '0;
    if1.load_en = 1'b0; if1.load_addr = '0; if1.load_data = '0;
    for (int i = 0; i < 256; i++) ref0[i] = 16'h0000;
    for (int i = 0; i < 16; i++) ref1[i] = 16'h0000;
    test_reset();
    test_preload_read();
    test_write_read();
    test_out_of_range();
    test_reset_in_wait();
    test_load_and_req();
    test_random();
    test_zero_wait();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
